seq_pp_multiplier: RTL

- Parametrised, iterative partial-product multiplier and the successor to the fixed 2x2 combinational partial-product multipliers.
- Each cycle it generates ROWS_PER_CYCLE AND-rows of partial products and column-accumulates them into a 2*WIDTH accumulator.
- Supports unsigned and signed (two's complement) operands, selected per transaction.
- Sits between producer and consumer stages with valid/ready handshakes on both sides.

---
 rtl/seq_pp_multiplier.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seq_pp_multiplier.sv
// ----------------------------------------------------------------------------
// seq_pp_multiplier
//
// Iterative partial-product multiplier. On each RUN cycle it forms
// ROWS_PER_CYCLE AND-rows of partial products and adds them into a
// 2*WIDTH accumulator. It takes K = WIDTH/ROWS_PER_CYCLE cycles per product.
// Operands may be unsigned or two's complement, and the choice is made per
// transaction. The core multiplies the magnitudes and applies the sign to
// the finished sum.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a, b, in_signed are valid
//   in_ready   out  block can accept an operation (state IDLE)
//   in_signed  in   1: a and b are two's complement, 0: unsigned
//   a          in   WIDTH-bit multiplicand
//   b          in   WIDTH-bit multiplier
//   out_valid  out  p holds a completed product (state DONE)
//   out_ready  in   consumer accepts p
//   p          out  2*WIDTH-bit product
//   busy       out  high whenever state is not IDLE
// ----------------------------------------------------------------------------
module seq_pp_multiplier #(
   parameter int unsigned WIDTH          = 4,
   parameter int unsigned ROWS_PER_CYCLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p,
   output logic                 busy
);

   localparam int unsigned K    = WIDTH / ROWS_PER_CYCLE;
   localparam int unsigned CW   = (K > 1) ? $clog2(K) : 1;
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   ash_q, ash_d;
   logic [WIDTH-1:0]     bsh_q, bsh_d;
   logic                 neg_q, neg_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   p_q, p_d;

   logic [WIDTH-1:0]     amag, bmag;
   logic [2*WIDTH-1:0]   acc_sum;
   logic [WIDTH-1:0]     bbit;

   // Operand magnitudes. Negating -2^(W-1) wraps to 2^(W-1). That is the
   // correct magnitude when it is read as an unsigned WIDTH-bit value.
   always_comb begin
      amag = (in_signed && a[WIDTH-1]) ? -a : a;
      bmag = (in_signed && b[WIDTH-1]) ? -b : b;
   end

   // Row i = cnt*ROWS_PER_CYCLE + r is handled through pre-shifted copies.
   // ash_q holds amag << (cnt*ROWS_PER_CYCLE). bsh_q holds
   // bmag >> (cnt*ROWS_PER_CYCLE). Row r of this cycle therefore tests
   // bsh_q[r] and adds ash_q << r.
   always_comb begin
      acc_sum = acc_q;
      bbit    = '0;
      for (int unsigned r = 0; r < ROWS_PER_CYCLE; r++) begin
         bbit = bsh_q >> r;
         if (bbit[0]) begin
            acc_sum = acc_sum + (ash_q << r);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ash_d   = ash_q;
      bsh_d   = bsh_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      p_d     = p_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               ash_d   = {{WIDTH{1'b0}}, amag};
               bsh_d   = bmag;
               neg_d   = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_sum;
            ash_d = ash_q << ROWS_PER_CYCLE;
            bsh_d = bsh_q >> ROWS_PER_CYCLE;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // p is loaded only here, so it stays stable through DONE and after.
               p_d     = neg_q ? -acc_sum : acc_sum;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ash_q   <= '0;
         bsh_q   <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ash_q   <= ash_d;
         bsh_q   <= bsh_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign p         = p_q;

endmodule
